// File: rtl/imc_mac_array.sv
// imc_mac_array: streaming multi-bank MAC.
// Each beat carries one input vector and one N_BANK x N_IN weight matrix. The
// per-bank dot products go through multiply, adder-tree and accumulate stages.
// A frame ends on in_last, and its results are held until the consumer takes them.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge where
// valid && ready. in_ready is a pure function of the frame state, never of
// in_valid. out_valid, out_bank, out_total and out_ovf stay stable until that
// transfer completes.
module imc_mac_array #(
    parameter int N_IN   = 16,
    parameter int N_BANK = 4,
    parameter int XW     = 4,
    parameter int WW     = 4,
    parameter int ACC_W  = 24
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    input  logic                              signed_mode,
    input  logic [N_IN*XW-1:0]                xin,
    input  logic [N_BANK*N_IN*WW-1:0]         wbank,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N_BANK*ACC_W-1:0]           out_bank,
    output logic [ACC_W+$clog2(N_BANK):0]     out_total,
    output logic [N_BANK-1:0]                 out_ovf
);

    localparam int PW  = XW + WW + 1;                 // product width
    localparam int SW  = XW + WW + $clog2(N_IN) + 1;  // bank sum width
    localparam int TW  = ACC_W + $clog2(N_BANK) + 1;  // total width
    localparam int AW1 = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    if (ACC_W < SW) begin : g_acc_w_check
        $error("imc_mac_array: ACC_W is narrower than one bank sum");
    end

    logic [1:0] state;
    logic       accept;
    logic       first_beat;
    logic       mode_q;
    logic       mode_eff;

    assign in_ready   = !rst && (state == ST_IDLE || state == ST_ACCUM);
    assign accept     = in_valid && in_ready;
    assign first_beat = (state == ST_IDLE);
    // The mode of the first beat governs the whole frame.
    assign mode_eff   = first_beat ? signed_mode : mode_q;
    assign out_valid  = (state == ST_HOLD);

    function automatic logic signed [PW-1:0] ext_x(input logic [XW-1:0] v, input logic sgn);
        ext_x = {{(PW-XW){sgn & v[XW-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] ext_w(input logic [WW-1:0] v, input logic sgn);
        ext_w = {{(PW-WW){sgn & v[WW-1]}}, v};
    endfunction

    // Element-wise products of the incoming beat; the exact product always fits PW bits.
    logic signed [PW-1:0] prod [N_BANK][N_IN];
    always_comb begin
        for (int b = 0; b < N_BANK; b++) begin
            for (int k = 0; k < N_IN; k++) begin
                prod[b][k] = ext_x(xin[k*XW +: XW], mode_eff) *
                             ext_w(wbank[(b*N_IN+k)*WW +: WW], mode_eff);
            end
        end
    end

    logic signed [PW-1:0] p1 [N_BANK][N_IN];
    logic                 v1, first1, last1;

    // Stage 1 data: capture products and frame markers of an accepted beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            p1     <= prod;
            first1 <= first_beat;
            last1  <= in_last;
        end
    end

    // Adder tree per bank, sign-extending every product.
    logic signed [SW-1:0] bsum [N_BANK];
    always_comb begin
        for (int b = 0; b < N_BANK; b++) begin
            bsum[b] = '0;
            for (int k = 0; k < N_IN; k++) begin
                bsum[b] = bsum[b] + SW'(p1[b][k]);
            end
        end
    end

    logic signed [SW-1:0] s2 [N_BANK];
    logic                 v2, first2, last2;

    // Stage 2 data: register the bank sums.
    always_ff @(posedge clk) begin
        if (v1) begin
            s2     <= bsum;
            first2 <= first1;
            last2  <= last1;
        end
    end

    logic signed [ACC_W-1:0] acc     [N_BANK];
    logic signed [AW1-1:0]   acc_sum [N_BANK];
    logic signed [ACC_W-1:0] acc_nxt [N_BANK];
    logic [N_BANK-1:0]       sat;
    logic [N_BANK-1:0]       ovf;
    logic                    done3;

    // Next accumulator value: load on a frame's first beat, else add with clamping.
    always_comb begin
        for (int b = 0; b < N_BANK; b++) begin
            acc_sum[b] = AW1'(acc[b]) + AW1'(s2[b]);
            acc_nxt[b] = acc_sum[b][ACC_W-1:0];
            sat[b]     = 1'b0;
            if (first2) begin
                acc_nxt[b] = ACC_W'(s2[b]);
            end else if (acc_sum[b][ACC_W] != acc_sum[b][ACC_W-1]) begin
                sat[b]     = 1'b1;
                acc_nxt[b] = acc_sum[b][ACC_W] ? ACC_MIN : ACC_MAX;
            end
        end
    end

    // Pipeline valids, accumulators and sticky saturation flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            done3 <= 1'b0;
            ovf   <= '0;
            for (int b = 0; b < N_BANK; b++) acc[b] <= '0;
        end else begin
            v1    <= accept;
            v2    <= v1;
            done3 <= v2 && last2;
            if (v2) begin
                for (int b = 0; b < N_BANK; b++) acc[b] <= acc_nxt[b];
                ovf <= (first2 ? '0 : ovf) | sat;
            end
        end
    end

    // Full-width cross-bank total of the clamped accumulators.
    logic signed [TW-1:0] total_nxt;
    always_comb begin
        total_nxt = '0;
        for (int b = 0; b < N_BANK; b++) total_nxt = total_nxt + TW'(acc[b]);
    end

    // Frame FSM; the frame mode is latched on the first accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mode_q <= signed_mode;
                        state  <= in_last ? ST_DRAIN : ST_ACCUM;
                    end
                end
                ST_ACCUM: if (accept && in_last) state <= ST_DRAIN;
                ST_DRAIN: if (done3) state <= ST_HOLD;
                ST_HOLD:  if (out_ready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Result registers load once the last beat has reached the accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bank  <= '0;
            out_total <= '0;
            out_ovf   <= '0;
        end else if (state == ST_DRAIN && done3) begin
            for (int b = 0; b < N_BANK; b++) out_bank[b*ACC_W +: ACC_W] <= acc[b];
            out_total <= total_nxt;
            out_ovf   <= ovf;
        end
    end

endmodule

// File: tb/tb_imc_mac_array.sv
// Testbench for imc_mac_array: a default instance (ACC_W=24) and a narrow
// instance (ACC_W=13) share all inputs; a reference model feeds per-instance
// expected-result queues that are checked at each output handshake.
module tb_imc_mac_array;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_last, signed_mode, out_ready;
    logic [63:0]  xin;
    logic [255:0] wbank;
    logic         in_ready, out_valid;
    logic [95:0]  out_bank;
    logic [26:0]  out_total;
    logic [3:0]   out_ovf;
    logic         in_ready_s, out_valid_s;
    logic [51:0]  out_bank_s;
    logic [15:0]  out_total_s;
    logic [3:0]   out_ovf_s;

    imc_mac_array dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .signed_mode(signed_mode), .xin(xin), .wbank(wbank), .out_valid(out_valid),
        .out_ready(out_ready), .out_bank(out_bank), .out_total(out_total), .out_ovf(out_ovf)
    );

    imc_mac_array #(.ACC_W(13)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
        .signed_mode(signed_mode), .xin(xin), .wbank(wbank), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_bank(out_bank_s), .out_total(out_total_s), .out_ovf(out_ovf_s)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- stimulus storage and reference model ----------------
    logic [3:0]   xv [16];
    logic [3:0]   wv [4][16];
    longint       macc_m [4];
    longint       macc_s [4];
    logic [3:0]   ovf_m, ovf_s;
    bit           first_f = 1'b1;
    bit           mode_f  = 1'b0;
    logic [126:0] exp_q   [$];
    logic [71:0]  exp_s_q [$];
    logic [126:0] em;
    logic [71:0]  es;

    function automatic longint ext4(input logic [3:0] v, input bit m);
        if (m) return longint'($signed(v));
        return longint'(v);
    endfunction

    function automatic longint clampv(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_beat(input bit last, input bit mode);
        longint dot, sm, ss, tm, ts;
        logic [126:0] e;
        logic [71:0]  e2;
        if (first_f) mode_f = mode;
        for (int b = 0; b < 4; b++) begin
            dot = 0;
            for (int k = 0; k < 16; k++) dot += ext4(xv[k], mode_f) * ext4(wv[b][k], mode_f);
            sm = first_f ? dot : macc_m[b] + dot;
            ss = first_f ? dot : macc_s[b] + dot;
            macc_m[b] = clampv(sm, 24);
            macc_s[b] = clampv(ss, 13);
            if (first_f) begin
                ovf_m[b] = 1'b0;
                ovf_s[b] = 1'b0;
            end
            if (macc_m[b] != sm) ovf_m[b] = 1'b1;
            if (macc_s[b] != ss) ovf_s[b] = 1'b1;
        end
        first_f = last;
        if (last) begin
            e = '0; e2 = '0; tm = 0; ts = 0;
            for (int b = 0; b < 4; b++) begin
                e[b*24 +: 24]  = macc_m[b][23:0];
                e2[b*13 +: 13] = macc_s[b][12:0];
                tm += macc_m[b];
                ts += macc_s[b];
            end
            e[96 +: 27]  = tm[26:0];
            e[123 +: 4]  = ovf_m;
            e2[52 +: 16] = ts[15:0];
            e2[68 +: 4]  = ovf_s;
            exp_q.push_back(e);
            exp_s_q.push_back(e2);
        end
    endtask

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_w_default();
        for (int k = 0; k < 16; k++) begin
            wv[0][k] = 4'(k);
            wv[1][k] = 4'(15 - k);
            wv[2][k] = 4'(2 * ((k % 7) + 1));
            wv[3][k] = 4'(2 * (k % 8) + 1);
        end
    endtask

    task automatic set_all(input logic [3:0] xval, input logic [3:0] wval);
        for (int k = 0; k < 16; k++) begin
            xv[k] = xval;
            for (int b = 0; b < 4; b++) wv[b][k] = wval;
        end
    endtask

    task automatic drive_beat(input bit last, input bit mode);
        int n;
        for (int k = 0; k < 16; k++) xin[k*4 +: 4] = xv[k];
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 16; k++) wbank[(b*16+k)*4 +: 4] = wv[b][k];
        in_valid    = 1'b1;
        in_last     = last;
        signed_mode = mode;
        n = 0;
        while (!(in_ready && in_ready_s) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_beat(last, mode);
    endtask

    // Counts cycles from the last acceptance to out_valid; in_ready must stay low.
    task automatic wait_result(input string tag);
        int lat;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk({tag, "_ready_low"}, {31'b0, in_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd4);
        chk({tag, "_ready_hold"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic release_out(input string tag);
        int n;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        n = 0;
        while (out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic check_main(input string tag, input int b0, input int b1, input int b2,
                              input int b3, input int tot, input logic [3:0] ovf);
        int          eb [4];
        logic [23:0] e24;
        logic [26:0] e27;
        eb = '{b0, b1, b2, b3};
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        for (int b = 0; b < 4; b++) begin
            e24 = 24'(eb[b]);
            total++;
            assert (out_bank[b*24 +: 24] === e24) else begin
                bad++;
                $error("FAIL %s_bank%0d observed=%0d expected=%0d", tag, b,
                       $signed(out_bank[b*24 +: 24]), $signed(e24));
            end
        end
        e27 = 27'(tot);
        total++;
        assert (out_total === e27) else begin
            bad++;
            $error("FAIL %s_total observed=%0d expected=%0d", tag, $signed(out_total), $signed(e27));
        end
        chk({tag, "_ovf"}, {28'b0, out_ovf}, {28'b0, ovf});
    endtask

    // ---------------- scoreboards ----------------
    // Pop and compare at the negedge before a handshake edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $error("FAIL sb_main observed=unexpected result expected=none");
            end else begin
                em = exp_q.pop_front();
                total++;
                assert (out_bank === em[95:0]) else begin
                    bad++; $error("FAIL sb_main_bank observed=%0h expected=%0h", out_bank, em[95:0]);
                end
                total++;
                assert (out_total === em[122:96]) else begin
                    bad++; $error("FAIL sb_main_total observed=%0h expected=%0h", out_total, em[122:96]);
                end
                total++;
                assert (out_ovf === em[126:123]) else begin
                    bad++; $error("FAIL sb_main_ovf observed=%0h expected=%0h", out_ovf, em[126:123]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_s && out_ready) begin
            if (exp_s_q.size() == 0) begin
                total++; bad++;
                $error("FAIL sb_small observed=unexpected result expected=none");
            end else begin
                es = exp_s_q.pop_front();
                total++;
                assert (out_bank_s === es[51:0]) else begin
                    bad++; $error("FAIL sb_small_bank observed=%0h expected=%0h", out_bank_s, es[51:0]);
                end
                total++;
                assert (out_total_s === es[67:52]) else begin
                    bad++; $error("FAIL sb_small_total observed=%0h expected=%0h", out_total_s, es[67:52]);
                end
                total++;
                assert (out_ovf_s === es[71:68]) else begin
                    bad++; $error("FAIL sb_small_ovf observed=%0h expected=%0h", out_ovf_s, es[71:68]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int nb;
        bit md;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; signed_mode = 1'b0;
        out_ready = 1'b1; xin = '0; wbank = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_bank_zero", {31'b0, out_bank === '0}, 32'd1);
        chk("rst_out_total_zero", {31'b0, out_total === '0}, 32'd1);
        chk("rst_out_ovf", {28'b0, out_ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // 1: single unsigned beat
        set_w_default();
        for (int k = 0; k < 16; k++) xv[k] = 4'(k);
        drive_beat(1'b1, 1'b0);
        wait_result("t1");
        check_main("t1", 1240, 560, 928, 1128, 3856, 4'h0);
        release_out("t1");

        // 2: reversed input vector
        for (int k = 0; k < 16; k++) xv[k] = 4'(15 - k);
        drive_beat(1'b1, 1'b0);
        wait_result("t2");
        check_main("t2", 560, 1240, 842, 792, 3434, 4'h0);
        release_out("t2");

        // 3: two back-to-back beats; the mode flip on beat 2 must be ignored
        for (int k = 0; k < 16; k++) xv[k] = 4'(k);
        drive_beat(1'b0, 1'b0);
        for (int k = 0; k < 16; k++) xv[k] = 4'(15 - k);
        drive_beat(1'b1, 1'b1);
        wait_result("t3");
        check_main("t3", 1800, 1800, 1770, 1920, 7290, 4'h0);
        release_out("t3");

        // 4: signed versus unsigned interpretation
        set_all(4'hF, 4'h7);
        drive_beat(1'b1, 1'b1);
        wait_result("t4s");
        check_main("t4s", -112, -112, -112, -112, -448, 4'h0);
        release_out("t4s");
        drive_beat(1'b1, 1'b0);
        wait_result("t4u");
        check_main("t4u", 1680, 1680, 1680, 1680, 6720, 4'h0);
        release_out("t4u");

        // 5: saturation in the narrow instance
        set_all(4'hF, 4'hF);
        drive_beat(1'b0, 1'b0);
        drive_beat(1'b1, 1'b0);
        wait_result("t5");
        check_main("t5", 7200, 7200, 7200, 7200, 28800, 4'h0);
        for (int b = 0; b < 4; b++)
            chk("t5_small_bank", {19'b0, out_bank_s[b*13 +: 13]}, 32'd4095);
        chk("t5_small_total", {16'b0, out_total_s}, 32'd16380);
        chk("t5_small_ovf", {28'b0, out_ovf_s}, 32'hF);
        release_out("t5");

        // 6a: backpressure holds the result for 10 cycles
        set_w_default();
        for (int k = 0; k < 16; k++) xv[k] = 4'(k);
        out_ready = 1'b0;
        drive_beat(1'b1, 1'b0);
        wait_result("t6a");
        for (int i = 0; i < 10; i++) begin
            check_main("t6a_hold", 1240, 560, 928, 1128, 3856, 4'h0);
            chk("t6a_hold_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        release_out("t6a");

        // 6b: reset mid-frame discards the frame in flight
        set_all(4'hF, 4'hF);
        drive_beat(1'b0, 1'b0);
        rst = 1'b1;
        first_f = 1'b1;
        exp_q.delete();
        exp_s_q.delete();
        @(negedge clk);
        chk("t6b_rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("t6b_rst_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6b_post_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("t6b_post_rst_bank_zero", {31'b0, out_bank === '0}, 32'd1);
        set_w_default();
        for (int k = 0; k < 16; k++) xv[k] = 4'(k);
        drive_beat(1'b1, 1'b0);
        wait_result("t6b");
        check_main("t6b", 1240, 560, 928, 1128, 3856, 4'h0);
        chk("t6b_small_ovf", {28'b0, out_ovf_s}, 32'd0);
        release_out("t6b");

        // random frames checked by the scoreboards
        for (int f = 0; f < 4; f++) begin
            nb = $urandom_range(1, 3);
            md = 1'($urandom_range(0, 1));
            out_ready = 1'b0;
            for (int i = 0; i < nb; i++) begin
                for (int k = 0; k < 16; k++) begin
                    xv[k] = 4'($urandom_range(0, 15));
                    for (int b = 0; b < 4; b++) wv[b][k] = 4'($urandom_range(0, 15));
                end
                drive_beat(i == nb - 1, md);
            end
            wait_result("rnd");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_out("rnd");
        end

        repeat (3) @(negedge clk);
        chk("sb_main_empty", exp_q.size(), 32'd0);
        chk("sb_small_empty", exp_s_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
